scratchpad_memory_stage1: RTL

SCRATCHPAD_MEMORY_STAGE1 -- requirements
Module: scratchpad_memory_stage1

---
 rtl/npu_spm_defines.sv | 34 +++
 rtl/sm_conflict_resolver.sv | 45 ++++
 rtl/scratchpad_memory_stage1.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/npu_spm_defines.sv
// Shared scratchpad-memory parameters, types and address-split helpers.
package npu_spm_defines;

    localparam int SM_PROCESSING_ELEMENTS = 16;
    localparam int SM_MEMORY_BANKS        = 16;
    localparam int SM_BYTES_PER_WORD      = 4;
    localparam int SM_ENTRIES_PER_BANK    = 1024;
    localparam int SM_ADDRESS_LEN         = 32;
    localparam int SM_DATA_LEN            = 32;
    localparam int SM_PIGGYBACK_DATA_LEN  = 8;

    localparam int SM_WORD_SHIFT      = $clog2(SM_BYTES_PER_WORD);
    localparam int SM_BANK_ADDR_LEN   = $clog2(SM_MEMORY_BANKS);
    localparam int SM_ENTRY_ADDR_LEN  = $clog2(SM_ENTRIES_PER_BANK);
    localparam int SM_BYTE_MASK_LEN   = SM_DATA_LEN / 8;

    typedef logic [SM_ADDRESS_LEN-1:0]         sm_address_t;
    typedef logic [SM_BANK_ADDR_LEN-1:0]       sm_bank_address_t;
    typedef logic [SM_ENTRY_ADDR_LEN-1:0]      sm_entry_address_t;
    typedef logic [SM_DATA_LEN-1:0]            sm_data_t;
    typedef logic [SM_BYTE_MASK_LEN-1:0]       sm_byte_mask_t;
    typedef logic [SM_PROCESSING_ELEMENTS-1:0] sm_lane_mask_t;

    // Bank index: low bits of the word address (byte address >> word shift).
    function automatic sm_bank_address_t sm_bank_of(input sm_address_t addr);
        return addr[SM_WORD_SHIFT +: SM_BANK_ADDR_LEN];
    endfunction

    // Entry offset inside the bank: the word-address bits just above the bank index.
    function automatic sm_entry_address_t sm_offset_of(input sm_address_t addr);
        return addr[SM_WORD_SHIFT + SM_BANK_ADDR_LEN +: SM_ENTRY_ADDR_LEN];
    endfunction

endpackage

// File: rtl/sm_conflict_resolver.sv
// Combinational per-bank arbitration: picks which pending lanes may access
// the banks in the current cycle without a bank conflict.
module sm_conflict_resolver
    import npu_spm_defines::*;
(
    input  sm_lane_mask_t                                   i_pending_mask,
    input  sm_bank_address_t  [SM_PROCESSING_ELEMENTS-1:0]  i_bank_indexes,
    input  sm_entry_address_t [SM_PROCESSING_ELEMENTS-1:0]  i_bank_offsets,
    input  logic                                            i_is_store,
    output sm_lane_mask_t                                   o_grant
);

    logic [SM_MEMORY_BANKS-1:0] w_bank_claimed;
    sm_entry_address_t          w_winner_offset [SM_MEMORY_BANKS];
    sm_lane_mask_t              w_is_winner;

    // Walk lanes in ascending order: the first pending lane to reach a bank wins it.
    always_comb begin
        // NOTE: every variable gets a default before the loop, so no path holds an old value and no latch is inferred.
        w_bank_claimed = '0;
        w_is_winner    = '0;
        for (int b = 0; b < SM_MEMORY_BANKS; b++) begin
            w_winner_offset[b] = '0;
        end
        for (int l = 0; l < SM_PROCESSING_ELEMENTS; l++) begin
            if (i_pending_mask[l] && !w_bank_claimed[i_bank_indexes[l]]) begin
                w_bank_claimed[i_bank_indexes[l]]  = 1'b1;
                w_winner_offset[i_bank_indexes[l]] = i_bank_offsets[l];
                w_is_winner[l]                     = 1'b1;
            end
        end
    end

    // Winners always go; loads additionally broadcast to lanes reading the winner's entry.
    always_comb begin
        o_grant = '0;
        for (int l = 0; l < SM_PROCESSING_ELEMENTS; l++) begin
            o_grant[l] = i_pending_mask[l] &
                         (w_is_winner[l] |
                          (~i_is_store &
                           (i_bank_offsets[l] == w_winner_offset[i_bank_indexes[l]])));
        end
    end

endmodule

// File: rtl/scratchpad_memory_stage1.sv
// Scratchpad stage 1: accepts a vector memory request, splits each lane
// address into bank/offset and serialises bank-conflicting lanes into a
// sequence of conflict-free issues towards stage 2.
module scratchpad_memory_stage1
    import npu_spm_defines::*;
(
    input  logic                                            clock,
    input  logic                                            resetn,

    input  logic                                            sm0_valid,
    input  logic                                            sm0_is_store,
    input  sm_address_t       [SM_PROCESSING_ELEMENTS-1:0]  sm0_addresses,
    input  sm_data_t          [SM_PROCESSING_ELEMENTS-1:0]  sm0_write_data,
    input  sm_byte_mask_t     [SM_PROCESSING_ELEMENTS-1:0]  sm0_byte_mask,
    input  logic              [SM_PROCESSING_ELEMENTS-1:0]  sm0_mask,
    input  logic              [SM_PIGGYBACK_DATA_LEN-1:0]   sm0_piggyback_data,

    output logic                                            sm1_ready,

    output logic                                            sm1_is_store,
    output logic                                            sm1_is_last_request,
    output sm_bank_address_t  [SM_PROCESSING_ELEMENTS-1:0]  sm1_bank_indexes,
    output sm_entry_address_t [SM_PROCESSING_ELEMENTS-1:0]  sm1_bank_offsets,
    output logic              [SM_PROCESSING_ELEMENTS-1:0]  sm1_satisfied_mask,
    output sm_data_t          [SM_PROCESSING_ELEMENTS-1:0]  sm1_write_data,
    output sm_byte_mask_t     [SM_PROCESSING_ELEMENTS-1:0]  sm1_byte_mask,
    output logic              [SM_PROCESSING_ELEMENTS-1:0]  sm1_mask,
    output logic              [SM_PIGGYBACK_DATA_LEN-1:0]   sm1_piggyback_data
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_ISSUE = 1'b1;

    // Control state
    logic [0:0]      r_state;
    logic            r_ready;
    sm_lane_mask_t   r_pending;
    sm_lane_mask_t   r_satisfied;
    logic            r_is_last;

    // Request fields latched at accept and held for every issue
    logic                                           r_is_store;
    sm_bank_address_t  [SM_PROCESSING_ELEMENTS-1:0] r_bank_indexes;
    sm_entry_address_t [SM_PROCESSING_ELEMENTS-1:0] r_bank_offsets;
    sm_data_t          [SM_PROCESSING_ELEMENTS-1:0] r_write_data;
    sm_byte_mask_t     [SM_PROCESSING_ELEMENTS-1:0] r_byte_mask;
    sm_lane_mask_t                                  r_mask;
    logic [SM_PIGGYBACK_DATA_LEN-1:0]               r_piggyback_data;

    // Combinational helpers
    logic                                           w_accept;
    sm_lane_mask_t                                  w_grant;
    sm_lane_mask_t                                  w_remaining;
    logic                                           w_is_last;
    sm_bank_address_t  [SM_PROCESSING_ELEMENTS-1:0] w_in_bank;
    sm_entry_address_t [SM_PROCESSING_ELEMENTS-1:0] w_in_offset;
    logic                                           w_unused_addr_bits;

    // r_ready is only ever high in IDLE, so it alone qualifies the handshake.
    assign w_accept    = sm0_valid & r_ready;
    assign w_remaining = r_pending & ~w_grant;
    assign w_is_last   = (w_remaining == '0);

    // Byte-within-word bits and address bits above the offset field play no role in banking.
    assign w_unused_addr_bits = ^sm0_addresses;

    // Split each incoming lane address into bank index and in-bank offset.
    always_comb begin
        w_in_bank   = '0;
        w_in_offset = '0;
        for (int l = 0; l < SM_PROCESSING_ELEMENTS; l++) begin
            w_in_bank[l]   = sm_bank_of(sm0_addresses[l]);
            w_in_offset[l] = sm_offset_of(sm0_addresses[l]);
        end
    end

    sm_conflict_resolver u_conflict_resolver (
        .i_pending_mask (r_pending),
        .i_bank_indexes (r_bank_indexes),
        .i_bank_offsets (r_bank_offsets),
        .i_is_store     (r_is_store),
        .o_grant        (w_grant)
    );

    // FSM: accept in IDLE, then issue one conflict-free lane group per cycle until none remain.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state     <= ST_IDLE;
            r_ready     <= 1'b0;
            r_pending   <= '0;
            r_satisfied <= '0;
            r_is_last   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments; the bubble defaults below are overridden by later writes in ISSUE.
            r_satisfied <= '0;
            r_is_last   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_pending <= sm0_mask;
                        r_state   <= ST_ISSUE;
                        r_ready   <= 1'b0;
                    end else begin
                        r_ready   <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    r_satisfied <= w_grant;
                    r_is_last   <= w_is_last;
                    r_pending   <= w_remaining;
                    if (w_is_last) begin
                        r_state <= ST_IDLE;
                        r_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    // Latch the request payload on accept; it stays stable for all issues of that request.
    always_ff @(posedge clock or negedge resetn) begin
        // NOTE: these are plain flops, not a memory array, so resetting them is cheap and clears the outputs.
        if (!resetn) begin
            r_is_store       <= 1'b0;
            r_bank_indexes   <= '0;
            r_bank_offsets   <= '0;
            r_write_data     <= '0;
            r_byte_mask      <= '0;
            r_mask           <= '0;
            r_piggyback_data <= '0;
        end else if (w_accept) begin
            r_is_store       <= sm0_is_store;
            r_bank_indexes   <= w_in_bank;
            r_bank_offsets   <= w_in_offset;
            r_write_data     <= sm0_write_data;
            r_byte_mask      <= sm0_byte_mask;
            r_mask           <= sm0_mask;
            r_piggyback_data <= sm0_piggyback_data;
        end
    end

    assign sm1_ready           = r_ready;
    assign sm1_is_store        = r_is_store;
    assign sm1_is_last_request = r_is_last;
    assign sm1_bank_indexes    = r_bank_indexes;
    assign sm1_bank_offsets    = r_bank_offsets;
    assign sm1_satisfied_mask  = r_satisfied;
    assign sm1_write_data      = r_write_data;
    assign sm1_byte_mask       = r_byte_mask;
    assign sm1_mask            = r_mask;
    assign sm1_piggyback_data  = r_piggyback_data;

endmodule
